// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_pattern_gen
//  Description : Test-pattern video source. Emits frames of PX_PER_CLK pixels
//                per beat with line/frame markers, horizontal and vertical
//                blanking, and four selectable patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen #(
    parameter  int PX_WIDTH      = 10,
    parameter  int PX_PER_CLK    = 4,
    parameter  int MAX_LINE_SIZE = 4112,
    parameter  int MAX_LINES     = 4096,
    localparam int LW            = $clog2(MAX_LINE_SIZE + 1),
    localparam int HW            = $clog2(MAX_LINES + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           run_i,
    input  logic [LW-1:0]                  frame_width_i,
    input  logic [HW-1:0]                  frame_height_i,
    input  logic [15:0]                    h_blank_i,
    input  logic [15:0]                    v_blank_i,
    input  logic [1:0]                     pattern_i,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic                           busy_o
);

    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_ACTIVE = 2'd1;
    localparam logic [1:0]  c_HBLANK = 2'd2;
    localparam logic [1:0]  c_VBLANK = 2'd3;
    localparam logic [LW:0] c_X_STEP = (LW+1)'(PX_PER_CLK);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [LW-1:0] r_x;
    logic [LW-1:0] w_x_nxt;
    logic [HW-1:0] r_y;
    logic [HW-1:0] w_y_nxt;
    logic [15:0]   r_blank_cnt;
    logic [15:0]   w_blank_nxt;
    logic [7:0]    r_frame_cnt;
    logic [7:0]    w_frame_nxt;

    logic [LW-1:0] r_width;
    logic [HW-1:0] r_height;
    logic [15:0]   r_h_blank;
    logic [15:0]   r_v_blank;
    logic [1:0]    r_pattern;

    logic          w_cfg_ok;
    logic          w_latch;
    logic          w_frame_done;
    logic          w_line_last;
    logic          w_last_line;

    // Configuration seen by the beat being prepared: the live inputs on the
    // cycle they are latched, the latched copy otherwise.
    logic [LW-1:0] w_width_eff;
    logic [HW-1:0] w_height_eff;
    logic [1:0]    w_pattern_eff;

    logic                           w_active_nxt;
    logic                           w_line_start_nxt;
    logic                           w_line_end_nxt;
    logic                           w_frame_start_nxt;
    logic                           w_frame_end_nxt;
    logic [PX_PER_CLK-1:0]          w_val_nxt;
    logic [PX_PER_CLK*PX_WIDTH-1:0] w_px_nxt;

    assign w_cfg_ok    = run_i && (frame_width_i != '0) && (frame_height_i != '0);
    assign w_line_last = ({1'b0, r_x} + c_X_STEP) >= {1'b0, r_width};
    assign w_last_line = ({1'b0, r_y} + (HW+1)'(1)) >= {1'b0, r_height};

    // Next-state, counter and latch decisions; outputs are derived from the
    // next-state values so every output register lines up with the state.
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_blank_nxt  = r_blank_cnt;
        w_frame_nxt  = r_frame_cnt;
        w_latch      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_cfg_ok) begin
                    w_latch     = 1'b1;
                    w_state_nxt = c_ACTIVE;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_blank_nxt = '0;
                end
            end
            c_ACTIVE: begin
                if (!w_line_last) begin
                    w_x_nxt = r_x + LW'(PX_PER_CLK);
                end else begin
                    w_x_nxt = '0;
                    if (!w_last_line) begin
                        if (r_h_blank == '0) begin
                            w_y_nxt = r_y + HW'(1);
                        end else begin
                            w_state_nxt = c_HBLANK;
                            w_blank_nxt = 16'd1;
                        end
                    end else if (r_v_blank == '0) begin
                        w_frame_done = 1'b1;
                    end else begin
                        w_state_nxt = c_VBLANK;
                        w_blank_nxt = 16'd1;
                    end
                end
            end
            c_HBLANK: begin
                if (r_blank_cnt == r_h_blank) begin
                    w_state_nxt = c_ACTIVE;
                    w_y_nxt     = r_y + HW'(1);
                    w_blank_nxt = '0;
                end else begin
                    w_blank_nxt = r_blank_cnt + 16'd1;
                end
            end
            c_VBLANK: begin
                if (r_blank_cnt == r_v_blank) begin
                    w_frame_done = 1'b1;
                end else begin
                    w_blank_nxt = r_blank_cnt + 16'd1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase

        // End of frame (after any vertical blanking): restart or go idle.
        if (w_frame_done) begin
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_blank_nxt = '0;
            if (w_cfg_ok) begin
                w_latch     = 1'b1;
                w_frame_nxt = r_frame_cnt + 8'd1;
                w_state_nxt = c_ACTIVE;
            end else begin
                w_state_nxt = c_IDLE;
            end
        end
    end

    assign w_width_eff   = w_latch ? frame_width_i  : r_width;
    assign w_height_eff  = w_latch ? frame_height_i : r_height;
    assign w_pattern_eff = w_latch ? pattern_i      : r_pattern;

    assign w_active_nxt      = (w_state_nxt == c_ACTIVE);
    assign w_line_start_nxt  = w_active_nxt && (w_x_nxt == '0);
    assign w_line_end_nxt    = w_active_nxt &&
                               (({1'b0, w_x_nxt} + c_X_STEP) >= {1'b0, w_width_eff});
    assign w_frame_start_nxt = w_line_start_nxt && (w_y_nxt == '0);
    assign w_frame_end_nxt   = w_line_end_nxt &&
                               (({1'b0, w_y_nxt} + (HW+1)'(1)) >= {1'b0, w_height_eff});

    for (genvar p = 0; p < PX_PER_CLK; p++) begin : g_lane
        logic [LW:0]         w_lane_x;
        logic [PX_WIDTH-1:0] w_lane_pix;

        assign w_lane_x     = {1'b0, w_x_nxt} + (LW+1)'(p);
        assign w_val_nxt[p] = w_active_nxt && (w_lane_x < {1'b0, w_width_eff});

        // Pattern value for this lane, truncated to the pixel width.
        always_comb begin
            w_lane_pix = '0;
            case (w_pattern_eff)
                2'd0:    w_lane_pix = PX_WIDTH'(w_lane_x);
                2'd1:    w_lane_pix = PX_WIDTH'(w_y_nxt);
                2'd2:    w_lane_pix = PX_WIDTH'(w_lane_x) + PX_WIDTH'(w_y_nxt)
                                    + PX_WIDTH'(w_frame_nxt);
                default: w_lane_pix = {PX_WIDTH{w_lane_x[3] ^ w_y_nxt[3]}};
            endcase
        end

        assign w_px_nxt[p*PX_WIDTH +: PX_WIDTH] = w_val_nxt[p] ? w_lane_pix : '0;
    end

    // FSM state, position counters and latched configuration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_blank_cnt <= '0;
            r_frame_cnt <= '0;
            r_width     <= '0;
            r_height    <= '0;
            r_h_blank   <= '0;
            r_v_blank   <= '0;
            r_pattern   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_blank_cnt <= w_blank_nxt;
            r_frame_cnt <= w_frame_nxt;
            if (w_latch) begin
                r_width   <= frame_width_i;
                r_height  <= frame_height_i;
                r_h_blank <= h_blank_i;
                r_v_blank <= v_blank_i;
                r_pattern <= pattern_i;
            end
        end
    end

    // Registered pixel stream and markers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px_data_o     <= '0;
            px_data_val_o <= '0;
            line_start_o  <= 1'b0;
            line_end_o    <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            px_data_o     <= w_px_nxt;
            px_data_val_o <= w_val_nxt;
            line_start_o  <= w_line_start_nxt;
            line_end_o    <= w_line_end_nxt;
            frame_start_o <= w_frame_start_nxt;
            frame_end_o   <= w_frame_end_nxt;
            busy_o        <= (w_state_nxt != c_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameter PX_WIDTH, default 10, bits per pixel.
REQ-002 Parameter PX_PER_CLK, default 4, pixels per beat; lane 0 is the leftmost pixel.
REQ-003 Parameter MAX_LINE_SIZE, default 4112, maximum pixels per line; LW = $clog2(MAX_LINE_SIZE+1).
REQ-004 Parameter MAX_LINES, default 4096, maximum lines per frame; HW = $clog2(MAX_LINES+1).
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous and active-high.
REQ-007 run_i  in  1  level request: while high, frames are generated back-to-back.
REQ-008 frame_width_i  in  LW  active pixels per line.
REQ-009 frame_height_i  in  HW  lines per frame.
REQ-010 h_blank_i  in  16  idle cycles between lines.
REQ-011 v_blank_i  in  16  idle cycles after the last line of a frame.
REQ-012 pattern_i  in  2  pattern select.
REQ-013 px_data_o  out  PX_PER_CLK*PX_WIDTH  packed pixels; lane p occupies [p*PX_WIDTH +: PX_WIDTH].
REQ-014 px_data_val_o  out  PX_PER_CLK  per-lane valid mask.
REQ-015 line_start_o, line_end_o, frame_start_o, frame_end_o  out  1 each  stream markers.
REQ-016 busy_o  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states are IDLE, ACTIVE, HBLANK, VBLANK; all outputs are registered.
REQ-018 IDLE: when run_i=1, width>0 and height>0, latch width, height, h_blank, v_blank and pattern, clear x/y, and go to ACTIVE; the first beat appears on the cycle after run_i is sampled high.
REQ-019 Configuration inputs shall be ignored except at the latch points (IDLE exit and VBLANK exit).
REQ-020 IDLE with width=0 or height=0 shall stay IDLE, with no output and busy_o=0.
REQ-021 ACTIVE: one beat per cycle, no stalls; beat k carries x = k*PX_PER_CLK+p on lane p; beats per line = ceil(width/PX_PER_CLK).
REQ-022 Last beat of a line: lanes p < width - x_base are valid, the remaining upper lanes invalid with data 0; all other beats are fully valid.
REQ-023 line_start_o on the first beat of each line; line_end_o on the last beat; both high on a single-beat line.
REQ-024 frame_start_o together with line_start_o of line 0; frame_end_o together with line_end_o of the last line.
REQ-025 Markers are asserted only on beats with a nonzero px_data_val_o.
REQ-026 After a non-final line: HBLANK for h_blank cycles with val=0 and markers 0, then ACTIVE for y+1; h_blank=0 gives back-to-back lines.
REQ-027 After the final line: VBLANK for v_blank cycles (HBLANK not applied), then sample run_i.
REQ-028 At VBLANK exit with run_i=1 and a valid config: relatch the config, increment frame_cnt (8 bits, wraps), go to ACTIVE; otherwise go to IDLE.
REQ-029 Deasserting run_i mid-frame shall not truncate the frame; the frame completes, including VBLANK.
REQ-030 Patterns are truncated to PX_WIDTH:
  0 = x
  1 = y
  2 = x+y+frame_cnt
  3 = all-ones if (x[3]^y[3]) else 0.
REQ-031 Counters: x is LW bits, y is HW bits, blank counter is 16 bits; no counter exceeds its latched bound.

Reset
REQ-032 While rst_i=1 on a clock edge: state=IDLE, x=y=0, frame_cnt=0, px_data_o=0, px_data_val_o=0, all markers 0, busy_o=0.
REQ-033 Reset mid-line aborts immediately; no markers are emitted on the following cycle.

Verification
REQ-034 PX_PER_CLK=4, width=10, height=2, h_blank=3, v_blank=5, pattern 0, run_i pulsed 1 cycle -> per line, masks 1111, 1111, 0011 with lane data 0..9; 3 idle cycles between lines; frame_start on the first beat; frame_end on beat 6; then 5 VBLANK cycles, then IDLE.
REQ-035 width=3, height=1, h_blank=0 -> single beat with mask 0111 and line_start, line_end, frame_start, frame_end all 1.
REQ-036 run_i held high, pattern 2, width=4, height=1, v_blank=0 -> consecutive frames with lane-0 data equal to frame_cnt 0, 1, 2, ...; frame_cnt wraps from 255 to 0.
REQ-037 run_i dropped during line 1 of 4 -> all 4 lines are still emitted, then IDLE and busy_o=0.
REQ-038 rst_i asserted on the 2nd beat of a line -> next cycle all outputs 0; on a later run_i, restart at x=0, y=0, frame_cnt=0.
REQ-039 Scoreboard on all tests: every line carries exactly width valid pixels, markers appear only on valid beats, and configuration changes applied mid-frame have no effect until the next latch point.
